// File: rtl/rop_frag_serializer.sv
// Queues ROP request entries and serializes each entry's active fragments,
// lowest thread index first, toward the depth/stencil stage.
module rop_frag_serializer #(
    parameter int NUM_THREADS = 4,
    parameter int DIM_BITS    = 12,
    parameter int DEPTH_BITS  = 24,
    parameter int QUEUE_SIZE  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_THREADS-1:0]           in_tmask,
    input  logic [NUM_THREADS*DIM_BITS-1:0]  in_pos_x,
    input  logic [NUM_THREADS*DIM_BITS-1:0]  in_pos_y,
    input  logic [NUM_THREADS*32-1:0]        in_color,
    input  logic [NUM_THREADS*DEPTH_BITS-1:0] in_depth,
    input  logic [NUM_THREADS-1:0]           in_backface,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [((NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1)-1:0] out_tid,
    output logic [DIM_BITS-1:0]              out_pos_x,
    output logic [DIM_BITS-1:0]              out_pos_y,
    output logic [31:0]                      out_color,
    output logic [DEPTH_BITS-1:0]            out_depth,
    output logic                             out_backface,
    output logic                             out_last,
    output logic                             idle
);
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int PTR_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and the producer holds data while stalled.

    logic [NUM_THREADS-1:0]            tmask_q    [QUEUE_SIZE];
    logic [NUM_THREADS*DIM_BITS-1:0]   pos_x_q    [QUEUE_SIZE];
    logic [NUM_THREADS*DIM_BITS-1:0]   pos_y_q    [QUEUE_SIZE];
    logic [NUM_THREADS*32-1:0]         color_q    [QUEUE_SIZE];
    logic [NUM_THREADS*DEPTH_BITS-1:0] depth_q    [QUEUE_SIZE];
    logic [NUM_THREADS-1:0]            backface_q [QUEUE_SIZE];

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [NUM_THREADS-1:0] sent_mask;

    logic [NUM_THREADS-1:0]            pending;
    logic [NUM_THREADS-1:0]            tid_onehot;
    logic [NUM_THREADS*DIM_BITS-1:0]   head_pos_x;
    logic [NUM_THREADS*DIM_BITS-1:0]   head_pos_y;
    logic [NUM_THREADS*32-1:0]         head_color;
    logic [NUM_THREADS*DEPTH_BITS-1:0] head_depth;
    logic [NUM_THREADS-1:0]            head_backface;
    logic                              push;
    logic                              fire;
    logic                              pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign idle      = (count == '0);

    // Empty-mask entries complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_tmask != '0);
    assign fire = out_valid && out_ready;
    assign pop  = fire && out_last;

    assign head_pos_x    = pos_x_q[rd_ptr];
    assign head_pos_y    = pos_y_q[rd_ptr];
    assign head_color    = color_q[rd_ptr];
    assign head_depth    = depth_q[rd_ptr];
    assign head_backface = backface_q[rd_ptr];

    assign pending    = tmask_q[rd_ptr] & ~sent_mask;
    assign tid_onehot = pending & (~pending + NUM_THREADS'(1));
    assign out_last   = ((pending & (pending - NUM_THREADS'(1))) == '0);

    always_comb begin
        out_tid = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (tid_onehot[i]) out_tid = TID_W'(i);
        end
    end

    assign out_pos_x    = head_pos_x[out_tid*DIM_BITS +: DIM_BITS];
    assign out_pos_y    = head_pos_y[out_tid*DIM_BITS +: DIM_BITS];
    assign out_color    = head_color[out_tid*32 +: 32];
    assign out_depth    = head_depth[out_tid*DEPTH_BITS +: DEPTH_BITS];
    assign out_backface = head_backface[out_tid];

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            tmask_q[wr_ptr]    <= in_tmask;
            pos_x_q[wr_ptr]    <= in_pos_x;
            pos_y_q[wr_ptr]    <= in_pos_y;
            color_q[wr_ptr]    <= in_color;
            depth_q[wr_ptr]    <= in_depth;
            backface_q[wr_ptr] <= in_backface;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sent_mask <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (fire) sent_mask <= out_last ? '0 : (sent_mask | tid_onehot);
        end
    end
endmodule

// File: tb/tb_rop_frag_serializer.sv
// Directed and random stimulus for rop_frag_serializer, checked against a
// fragment-level reference queue built from each accepted entry's mask.
module tb_rop_frag_serializer;
    localparam int NT = 4;
    localparam int DB = 12;
    localparam int ZB = 24;
    localparam int QS = 4;
    localparam int TW = 2;
    localparam int FW = TW + DB + DB + 32 + ZB + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NT-1:0]     in_tmask = '0;
    logic [NT*DB-1:0]  in_pos_x = '0;
    logic [NT*DB-1:0]  in_pos_y = '0;
    logic [NT*32-1:0]  in_color = '0;
    logic [NT*ZB-1:0]  in_depth = '0;
    logic [NT-1:0]     in_backface = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [TW-1:0]     out_tid;
    logic [DB-1:0]     out_pos_x;
    logic [DB-1:0]     out_pos_y;
    logic [31:0]       out_color;
    logic [ZB-1:0]     out_depth;
    logic              out_backface;
    logic              out_last;
    logic              idle;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];
    bit last_acc;
    int waited;

    rop_frag_serializer #(
        .NUM_THREADS(NT), .DIM_BITS(DB), .DEPTH_BITS(ZB), .QUEUE_SIZE(QS)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_color(in_color),
        .in_depth(in_depth), .in_backface(in_backface),
        .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
        .out_pos_x(out_pos_x), .out_pos_y(out_pos_y), .out_color(out_color),
        .out_depth(out_depth), .out_backface(out_backface),
        .out_last(out_last), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] pack(input logic [TW-1:0] t, input logic [DB-1:0] x,
                                           input logic [DB-1:0] y, input logic [31:0] c,
                                           input logic [ZB-1:0] z, input logic b, input logic l);
        return {t, x, y, c, z, b, l};
    endfunction

    // Entries still held = entries whose final fragment has not yet left.
    function automatic int n_entries();
        int n = 0;
        foreach (exp_q[k]) if (exp_q[k][0]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry();
        int hi = -1;
        for (int i = 0; i < NT; i++) if (in_tmask[i]) hi = i;
        for (int i = 0; i < NT; i++) begin
            if (in_tmask[i])
                exp_q.push_back(pack(TW'(i), in_pos_x[i*DB +: DB], in_pos_y[i*DB +: DB],
                                     in_color[i*32 +: 32], in_depth[i*ZB +: ZB],
                                     in_backface[i], i == hi));
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit fire, acc;
        @(negedge clk);
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, n_entries() != QS);
        chk("idle", idle, exp_q.size() == 0);
        if (out_valid && exp_q.size() != 0)
            chk("frag", pack(out_tid, out_pos_x, out_pos_y, out_color, out_depth,
                             out_backface, out_last), exp_q[0]);
        fire = out_valid && out_ready;
        acc  = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (fire && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) push_entry();
        last_acc = acc;
    endtask

    task automatic rand_fields(input logic [NT-1:0] m);
        in_tmask = m;
        for (int i = 0; i < NT; i++) begin
            in_pos_x[i*DB +: DB] = DB'($urandom);
            in_pos_y[i*DB +: DB] = DB'($urandom);
            in_color[i*32 +: 32] = $urandom;
            in_depth[i*ZB +: ZB] = ZB'($urandom);
            in_backface[i]       = 1'($urandom);
        end
    endtask

    task automatic offer();
        in_valid = 1'b1;
        last_acc = 1'b0;
        waited = 0;
        while (!last_acc && waited < 40) begin
            cycle();
            waited++;
        end
        chk("accept", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < 60) begin
            cycle();
            k++;
        end
        chk("drain", exp_q.size(), 0);
        cycle();
    endtask

    initial begin
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Full entry, colors 0x11..0x44.
        rand_fields(4'b1111);
        in_color = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        offer();
        drain();

        // Sparse mask with known x positions.
        rand_fields(4'b1010);
        in_pos_x = {12'd40, 12'd30, 12'd20, 12'd10};
        offer();
        drain();

        // Empty mask is swallowed, then a single-thread entry.
        rand_fields(4'b0000);
        offer();
        rand_fields(4'b0001);
        offer();
        drain();

        // Fill under back-pressure, fifth entry waits for the first pop.
        out_ready = 1'b0;
        for (int e = 0; e < 4; e++) begin
            rand_fields(NT'(1) << e);
            offer();
        end
        rand_fields(4'b0100);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        out_ready = 1'b1;
        offer();
        chk("fifth_accept_cycles", waited, 2);
        drain();

        // Stall pattern across one full entry.
        rand_fields(4'b1111);
        offer();
        for (int k = 0; k < 8; k++) begin
            out_ready = (k % 2 == 0);
            cycle();
        end
        drain();

        // Asynchronous reset after two of four fragments.
        rand_fields(4'b1111);
        offer();
        while (exp_q.size() > 2) cycle();
        reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_idle", idle, 1'b1);
        chk("async_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        rand_fields(4'b1111);
        offer();
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            rand_fields(($urandom_range(0, 5) == 0) ? 4'b0000 : NT'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rop_frag_serializer.md
Name: rop_frag_serializer

Overview:
- Buffers ROP request entries (one per warp request: NUM_THREADS fragments plus thread mask) arriving from the core-side ROP request interface.
- Emits the active fragments one per handshake, lowest thread index first, to the downstream depth/stencil stage.
- Drops requests whose thread mask is empty. Provides an idle indication for flush/drain logic.

Parameters:
- NUM_THREADS, 4, fragments per request entry; must be ≥1.
- DIM_BITS, 12, width of each pixel coordinate.
- DEPTH_BITS, 24, width of the fragment depth value.
- QUEUE_SIZE, 4, number of request-entry slots; must be a power of two and ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request entry valid.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_tmask  in  NUM_THREADS  active-thread mask.
- in_pos_x  in  NUM_THREADS*DIM_BITS  per-thread x; thread i occupies bits [i*DIM_BITS +: DIM_BITS].
- in_pos_y  in  NUM_THREADS*DIM_BITS  per-thread y; same packing as in_pos_x.
- in_color  in  NUM_THREADS*32  per-thread ARGB8888 color.
- in_depth  in  NUM_THREADS*DEPTH_BITS  per-thread depth.
- in_backface  in  NUM_THREADS  per-thread backface flag.
- out_valid  out  1  fragment valid.
- out_ready  in  1  fragment consumed when out_valid && out_ready.
- out_tid  out  log2(NUM_THREADS), min 1  thread index of the presented fragment.
- out_pos_x  out  DIM_BITS  x of the presented fragment.
- out_pos_y  out  DIM_BITS  y of the presented fragment.
- out_color  out  32  color of the presented fragment.
- out_depth  out  DEPTH_BITS  depth of the presented fragment.
- out_backface  out  1  backface flag of the presented fragment.
- out_last  out  1  high when this is the final active fragment of its entry.
- idle  out  1  queue empty and no fragment pending.

Behaviour:
- Reset (reset=0, asynchronous): write pointer, read pointer, count and sent_mask all cleared to 0. out_valid=0, in_ready=1, idle=1. All other outputs are don't-care while out_valid=0; the bench must not check them then.
- Storage: circular buffer of QUEUE_SIZE entries. Pointers are log2(QUEUE_SIZE) bits and wrap from QUEUE_SIZE-1 to 0. count is log2(QUEUE_SIZE)+1 bits.
- in_ready = (count != QUEUE_SIZE). There is no full-queue bypass: in_ready is 0 when full, even if a pop occurs in the same cycle.
- Accept: on in_valid && in_ready with in_tmask != 0, write the entry at the write pointer, advance the write pointer and increment count.
- Accept with in_tmask == 0: handshake completes; nothing is stored and the pointers are unchanged.
- Latency: an entry accepted at edge N can appear on out_valid after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle; there is no combinational in-to-out path.
- Head selection:
  - pending = head.tmask & ~sent_mask.
  - out_valid = (count != 0).
  - out_tid = index of the lowest set bit of pending.
  - Output data fields = head fields at out_tid.
  - out_last = (pending has exactly one bit set).
- Fire (out_valid && out_ready):
  - If out_last: advance the read pointer, decrement count, and clear sent_mask to 0.
  - Otherwise: set bit out_tid in sent_mask.
- Simultaneous accept and pop in one cycle: count is unchanged and both pointers advance.
- Back-pressure: while out_valid && !out_ready, all out_* signals hold stable.
- idle = (count == 0).
- Reset mid-operation: all queued and partially sent entries are discarded immediately. Nothing is replayed after reset is released.
- Throughput: one fragment per cycle; a full entry with all threads active takes NUM_THREADS cycles.

Test Plan:
- Reset, then a single entry with tmask=4'b1111, colors 0x11..0x44, out_ready=1 → out_tid 0,1,2,3 on consecutive cycles starting 1 cycle after accept; out_last only with tid 3; idle returns to 1.
- Entry with tmask=4'b1010, pos_x={40,30,20,10} → exactly two fragments: tid1 (x=20, out_last=0), then tid3 (x=40, out_last=1).
- Entry with tmask=0 followed by an entry with tmask=4'b0001 → only one fragment emitted (tid0); the queue never holds more than 1 entry.
- out_ready=0 while 5 single-thread entries are offered → exactly 4 accepted, then in_ready=0. Release out_ready → 4 fragments emitted in order; the 5th entry is accepted the cycle after the first pop.
- out_ready toggled 1,0,1,0 during a 4-thread entry → out_* held stable in stall cycles; no fragment duplicated or lost.
- Assert reset low mid-entry (after 2 of 4 fragments) → out_valid=0 immediately (asynchronously); after release idle=1 and the next entry starts at tid 0.
